// File: rtl/level_meter_pkg.sv
// Shared constants and helpers for the stereo LED level meter (level_meter_bar).
// Covers threshold search from magnitude to LED count and the count-to-thermometer expansion.
package level_meter_pkg;

    localparam int LM_SAMPLE_WIDTH = 16;
    localparam int LM_LEDS         = 16;
    localparam int LM_CNT_W        = $clog2(LM_LEDS);

    // Number of 6 dB thresholds met: LED k needs mag >= 2^(sample_width-leds+k), k < leds-1.
    function automatic int mag_to_count(input int mag, input int sample_width, input int leds);
        int n;
        n = 0;
        for (int k = 0; k < 31; k++) begin
            if ((k < leds - 1) && (mag >= (1 << (sample_width - leds + k)))) begin
                n = k + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] count_to_therm(input int count);
        logic [31:0] t;
        for (int k = 0; k < 32; k++) begin
            t[k] = (k < count);
        end
        return t;
    endfunction

endpackage

// File: rtl/level_meter_bar_channel.sv
// One meter channel: magnitude, window peak, fall-back ballistics, clip hold and,
// with LEVEL_METER_PEAK_HOLD_EN defined, a peak-hold dot. Produces one LEDS-bit bar.
module level_meter_channel
    import level_meter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = LM_SAMPLE_WIDTH,
    parameter int LEDS         = LM_LEDS,
    parameter int CLIP_HOLD    = 8
`ifdef LEVEL_METER_PEAK_HOLD_EN
    ,
    parameter int HOLD_PERIODS = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_close,
    output logic [LEDS-1:0]         o_bar
);

    localparam int CNT_W = $clog2(LEDS);
    localparam int CT_W  = $clog2(CLIP_HOLD + 1);
    localparam logic [SAMPLE_WIDTH-1:0] MAX_POS = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [SAMPLE_WIDTH-1:0] MIN_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic [SAMPLE_WIDTH-2:0] mag;
    logic                    clip;
    logic [SAMPLE_WIDTH-2:0] wpk_q, wpk_d;
    logic                    clip_seen_q, clip_seen_d;
    logic [CNT_W-1:0]        count_q, count_d, wcount, count_dec;
    logic [CT_W-1:0]         ctimer_q, ctimer_d;
    logic                    clip_led_q, clip_led_d;

    always_comb begin
        clip = (i_sample == MAX_POS) || (i_sample == MIN_NEG);
        if (i_sample == MIN_NEG) begin
            mag = '1;
        end else if (i_sample[SAMPLE_WIDTH-1]) begin
            mag = ~i_sample[SAMPLE_WIDTH-2:0] + (SAMPLE_WIDTH-1)'(1);
        end else begin
            mag = i_sample[SAMPLE_WIDTH-2:0];
        end
    end

    // i_close marks the cycle after a window's last sample: wpk_q already holds the
    // full window peak, and any sample arriving now belongs to the next window.
    always_comb begin
        wpk_d       = wpk_q;
        clip_seen_d = clip_seen_q;
        count_d     = count_q;
        ctimer_d    = ctimer_q;
        clip_led_d  = clip_led_q;
        wcount      = CNT_W'(mag_to_count(int'(wpk_q), SAMPLE_WIDTH, LEDS));
        count_dec   = (count_q == '0) ? '0 : count_q - CNT_W'(1);
        if (i_close) begin
            wpk_d       = i_valid ? mag : '0;
            clip_seen_d = i_valid && clip;
            count_d     = (wcount > count_dec) ? wcount : count_dec;
            clip_led_d  = clip_seen_q || (ctimer_q != '0);
            if (clip_seen_q) begin
                ctimer_d = CT_W'(CLIP_HOLD);
            end else if (ctimer_q != '0) begin
                ctimer_d = ctimer_q - CT_W'(1);
            end
        end else if (i_valid) begin
            if (mag > wpk_q) begin
                wpk_d = mag;
            end
            clip_seen_d = clip_seen_q || clip;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wpk_q       <= '0;
            clip_seen_q <= 1'b0;
            count_q     <= '0;
            ctimer_q    <= '0;
            clip_led_q  <= 1'b0;
        end else begin
            wpk_q       <= wpk_d;
            clip_seen_q <= clip_seen_d;
            count_q     <= count_d;
            ctimer_q    <= ctimer_d;
            clip_led_q  <= clip_led_d;
        end
    end

`ifdef LEVEL_METER_PEAK_HOLD_EN
    localparam int HT_W = $clog2(HOLD_PERIODS + 1);

    logic [CNT_W-1:0] hp_q, hp_d;
    logic [HT_W-1:0]  ht_q, ht_d;
    logic [LEDS-1:0]  dot;

    always_comb begin
        hp_d = hp_q;
        ht_d = ht_q;
        if (i_close) begin
            if (count_d >= hp_q) begin
                hp_d = count_d;
                ht_d = HT_W'(HOLD_PERIODS);
            end else if (ht_q != '0) begin
                ht_d = ht_q - HT_W'(1);
            end else begin
                // count_d < hp_q here, so hp_q is nonzero
                hp_d = hp_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hp_q <= '0;
            ht_q <= '0;
        end else begin
            hp_q <= hp_d;
            ht_q <= ht_d;
        end
    end

    always_comb begin
        dot   = (hp_q != '0) ? (LEDS'(1) << (hp_q - CNT_W'(1))) : '0;
        o_bar = LEDS'(count_to_therm(int'(count_q))) | dot;
        o_bar[LEDS-1] = clip_led_q;
    end
`else
    always_comb begin
        o_bar = LEDS'(count_to_therm(int'(count_q)));
        o_bar[LEDS-1] = clip_led_q;
    end
`endif

endmodule

// File: rtl/level_meter_bar.sv
// Stereo level meter: per-window LED bar frames for the STP16 shifter over valid/ready.
// Define LEVEL_METER_PEAK_HOLD_EN to add the per-channel peak-hold dot.
module level_meter_bar
    import level_meter_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = LM_SAMPLE_WIDTH,
    parameter int LEDS           = LM_LEDS,
    parameter int UPDATE_SAMPLES = 1024,
    parameter int CLIP_HOLD      = 8
`ifdef LEVEL_METER_PEAK_HOLD_EN
    ,
    parameter int HOLD_PERIODS   = 16
`endif
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic                    i_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_left,
    input  logic [SAMPLE_WIDTH-1:0] i_right,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [2*LEDS-1:0]       o_data
);

    localparam int SCNT_W = $clog2(UPDATE_SAMPLES);
    localparam logic [SCNT_W-1:0] LAST = SCNT_W'(UPDATE_SAMPLES - 1);

    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              close_q, close_d;
    logic              upd_q, upd_d;
    logic              o_valid_q, o_valid_d;
    logic [2*LEDS-1:0] o_data_q, o_data_d;
    logic              pend_q, pend_d;
    logic [2*LEDS-1:0] pend_data_q, pend_data_d;
    logic [LEDS-1:0]   bar_l, bar_r;
    logic [2*LEDS-1:0] frame;
    logic              slot_free;

    level_meter_channel #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .LEDS        (LEDS),
        .CLIP_HOLD   (CLIP_HOLD)
`ifdef LEVEL_METER_PEAK_HOLD_EN
        ,
        .HOLD_PERIODS(HOLD_PERIODS)
`endif
    ) u_left (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_sample(i_left),
        .i_close (close_q),
        .o_bar   (bar_l)
    );

    level_meter_channel #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .LEDS        (LEDS),
        .CLIP_HOLD   (CLIP_HOLD)
`ifdef LEVEL_METER_PEAK_HOLD_EN
        ,
        .HOLD_PERIODS(HOLD_PERIODS)
`endif
    ) u_right (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_sample(i_right),
        .i_close (close_q),
        .o_bar   (bar_r)
    );

    // Handshake: a frame transfers on any edge with o_valid && o_ready; o_data is held
    // while o_valid && !o_ready. A frame that finds the slot busy parks in the pending
    // register, where a newer frame replaces it.
    always_comb begin
        scnt_d  = scnt_q;
        close_d = 1'b0;
        if (i_valid) begin
            close_d = (scnt_q == LAST);
            scnt_d  = close_d ? '0 : scnt_q + SCNT_W'(1);
        end
        upd_d       = close_q;
        frame       = {bar_l, bar_r};
        slot_free   = !o_valid_q || o_ready;
        o_valid_d   = o_valid_q;
        o_data_d    = o_data_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (upd_q) begin
            if (slot_free) begin
                o_valid_d = 1'b1;
                o_data_d  = frame;
                pend_d    = 1'b0;
            end else begin
                pend_d      = 1'b1;
                pend_data_d = frame;
            end
        end else if (slot_free && pend_q) begin
            o_valid_d = 1'b1;
            o_data_d  = pend_data_q;
            pend_d    = 1'b0;
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt_q      <= '0;
            close_q     <= 1'b0;
            upd_q       <= 1'b0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else begin
            scnt_q      <= scnt_d;
            close_q     <= close_d;
            upd_q       <= upd_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_level_meter_bar.sv
// Directed bench for level_meter_bar with 4-sample windows and a 2-window clip hold.
// Define LEVEL_METER_PEAK_HOLD_EN to exercise the peak-hold dot instead of the falling-bar cases.
module tb_level_meter_bar;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [15:0] i_left;
    logic [15:0] i_right;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;

    int n_vec = 0;
    int n_err = 0;

    level_meter_bar #(
        .SAMPLE_WIDTH  (16),
        .LEDS          (16),
        .UPDATE_SAMPLES(4),
        .CLIP_HOLD     (2)
`ifdef LEVEL_METER_PEAK_HOLD_EN
        ,
        .HOLD_PERIODS  (2)
`endif
    ) dut (
        .reset  (reset),
        .clk    (clk),
        .i_valid(i_valid),
        .i_left (i_left),
        .i_right(i_right),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data (o_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // drivers
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        i_valid = 1'b1;
        i_left  = l;
        i_right = r;
        step();
        i_valid = 1'b0;
    endtask

    task automatic send_window(input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < 4; i++) send(l, r);
    endtask

    task automatic wait_frame(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (o_valid === 1'b1) got = 1'b1;
        end
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b expected 0", o_valid);
        end
        n_vec++;
        if (o_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 00000000", o_data);
        end
    endtask

    task automatic test_latency();
        do_reset();
        send_window(16'h4000, 16'h0001);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_n0: got %b expected 0", o_valid);
        end
        step();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_n1: got %b expected 0", o_valid);
        end
        step();
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 32'h7FFF0001) begin
            n_err++;
            $display("FAIL latency_n2: got valid %b data %h expected 1 7fff0001", o_valid, o_data);
        end
        step();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_drop: got %b expected 0", o_valid);
        end
    endtask

    task automatic test_thresholds();
        logic [15:0] l_tab [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h00FF, 16'h0100, 16'h8001};
        logic [15:0] r_tab [6] = '{16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFF00, 16'hC000, 16'h7FFF};
        logic [31:0] e_tab [6] = '{32'h00000001, 32'h00010003, 32'h00030007,
                                   32'h00FF01FF, 32'h01FF7FFF, 32'h7FFFFFFF};
        bit got;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_window(l_tab[i], r_tab[i]);
            wait_frame(got);
            n_vec++;
            if (!got || o_data !== e_tab[i]) begin
                n_err++;
                $display("FAIL threshold_%0d: got valid %b data %h expected 1 %h", i, got, o_data, e_tab[i]);
            end
        end
    endtask

`ifndef LEVEL_METER_PEAK_HOLD_EN
    task automatic test_clip();
        logic [31:0] e_tab [5] = '{32'hFFFF0000, 32'hBFFF0000, 32'h9FFF0000,
                                   32'h0FFF0000, 32'h07FF0000};
        bit got;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_window((i == 0) ? 16'h8000 : 16'h0000, 16'h0000);
            wait_frame(got);
            n_vec++;
            if (!got || o_data !== e_tab[i]) begin
                n_err++;
                $display("FAIL clip_win%0d: got valid %b data %h expected 1 %h", i, got, o_data, e_tab[i]);
            end
        end
    endtask

    task automatic test_seed();
        do_reset();
        send_window(16'h0FFF, 16'h0000);
        send(16'h00FF, 16'h00FF);
        send(16'h0000, 16'h0000);
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 32'h0FFF0000) begin
            n_err++;
            $display("FAIL seed_first: got valid %b data %h expected 1 0fff0000", o_valid, o_data);
        end
        send(16'h0000, 16'h0000);
        send(16'h0000, 16'h0000);
        step();
        step();
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 32'h07FF00FF) begin
            n_err++;
            $display("FAIL seed_next: got valid %b data %h expected 1 07ff00ff", o_valid, o_data);
        end
    endtask
`else
    task automatic test_peak_hold();
        logic [31:0] e_tab [5] = '{32'h7FFF0000, 32'h7FFF0000, 32'h5FFF0000,
                                   32'h2FFF0000, 32'h17FF0000};
        bit got;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_window((i == 0) ? 16'h4000 : 16'h0000, 16'h0000);
            wait_frame(got);
            n_vec++;
            if (!got || o_data !== e_tab[i]) begin
                n_err++;
                $display("FAIL hold_win%0d: got valid %b data %h expected 1 %h", i, got, o_data, e_tab[i]);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        bit got;
        do_reset();
        o_ready = 1'b0;
        send_window(16'h0100, 16'h0000);
        wait_frame(got);
        n_vec++;
        if (!got || o_data !== 32'h01FF0000) begin
            n_err++;
            $display("FAIL stall_first: got valid %b data %h expected 1 01ff0000", got, o_data);
        end
        send_window(16'h1000, 16'h0000);
        send_window(16'h4000, 16'h0000);
        step();
        step();
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 32'h01FF0000) begin
            n_err++;
            $display("FAIL stall_hold: got valid %b data %h expected 1 01ff0000", o_valid, o_data);
        end
        o_ready = 1'b1;
        step();
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 32'h7FFF0000) begin
            n_err++;
            $display("FAIL stall_latest: got valid %b data %h expected 1 7fff0000", o_valid, o_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stall_drain_%0d: got valid %b data %h expected 0", i, o_valid, o_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        o_ready = 1'b0;
        send_window(16'h1000, 16'h0000);
        wait_frame(got);
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL rmid_setup: got valid %b expected 1", o_valid);
        end
        send(16'h03E8, 16'h03E8);
        send(16'h03E8, 16'h03E8);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_data !== 32'h0) begin
            n_err++;
            $display("FAIL rmid_async: got valid %b data %h expected 0 00000000", o_valid, o_data);
        end
        step();
        reset   = 1'b0;
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'h0100, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rmid_early_%0d: got valid %b expected 0", i, o_valid);
            end
        end
        send(16'h0100, 16'h0000);
        step();
        step();
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 32'h01FF0000) begin
            n_err++;
            $display("FAIL rmid_frame: got valid %b data %h expected 1 01ff0000", o_valid, o_data);
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        o_ready = 1'b1;
        test_reset();
        test_latency();
        test_thresholds();
`ifndef LEVEL_METER_PEAK_HOLD_EN
        test_clip();
        test_seed();
`else
        test_peak_hold();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/level_meter_bar.md
# level_meter_bar

Converts a stereo PCM sample stream into a 32-bit LED bar frame for a two-channel, 16-LED-per-channel level meter, and hands each frame to the downstream STP16 serial LED shifter over a valid/ready handshake. It sits between the audio sample source and the LED shifter. Per channel it:
- computes a log-scale (6 dB/LED) window peak;
- applies fall-back ballistics and clip hold, plus optional peak-hold dot.

## Interface
- SAMPLE_WIDTH, 16: signed PCM sample width; must be >= LEDS.
- LEDS, 16: LEDs per channel; LED LEDS-1 is the clip LED.
- UPDATE_SAMPLES, 1024: accepted samples per display window; >= 2.
- CLIP_HOLD, 8: update periods the clip LED stays lit after a clip.
- HOLD_PERIODS, 16: update periods the peak-hold dot is held (peak-hold build only).
- reset  in  1  asynchronous, active-high.
- clk  in  1  clock.
- i_valid  in  1  sample pair present; always accepted, no ready.
- i_left  in  SAMPLE_WIDTH  signed left sample.
- i_right  in  SAMPLE_WIDTH  signed right sample.
- o_valid  out  1  frame available.
- o_ready  in  1  downstream accepts frame.
- o_data  out  2*LEDS  frame {left_bar, right_bar}; bit 0 of each half = lowest LED.

## Operation
- Magnitude: mag = |x|, width SAMPLE_WIDTH-1; most-negative input saturates to 2^(SAMPLE_WIDTH-1)-1.
- Clip event: sample equals max positive or most negative.
- Window peak: wpk <= max(wpk, mag) per accepted sample.
  - On a window's last sample, the frame is computed from the peak including that sample.
  - A sample accepted on the cycle the window closes seeds the next window, so wpk <= that mag, not 0.
- wcount: number of thresholds met, LED k (0..LEDS-2) lit iff mag >= 2^(SAMPLE_WIDTH-LEDS+k); range 0..LEDS-1.
- Ballistics per window close: count <= max(wcount, count-1), with no underflow below 0.
- Clip LED:
  - A clip in the window loads the clip timer with CLIP_HOLD.
  - Otherwise the timer decrements at each window close, saturating at 0.
  - The LED is lit while the timer is nonzero.
- Bar: bits [count-1:0] set, bit LEDS-1 = clip LED, other bits 0.
- Output register:
  - Loaded with the new frame when the slot is free (!o_valid, or o_valid && o_ready on the same edge).
  - Otherwise the frame waits in a one-deep pending register; a newer frame overwrites the pending one, latest wins.
  - o_data stays stable while o_valid && !o_ready.
  - o_valid falls after a handshake unless a frame is pending or being loaded.
- Sample counter: counts accepted samples 0..UPDATE_SAMPLES-1 and wraps.

## Timing
- Reset values: o_valid 0, o_data 0. Counts, timers, wpk, sample counter, pending flag and hold registers are all 0.
- Reset mid-frame discards the frame; no frame is emitted until the first full window after reset.
- Latency, last sample of a window accepted at edge N:
  - count/clip registers update at edge N+1;
  - o_valid=1 with the frame at edge N+2 if the slot is free;
  - if the slot is busy, the frame loads on the handshake edge that frees it.
- Throughput: one sample pair per clk; the window close never stalls input.

## Configuration
- LEVEL_METER_PEAK_HOLD_EN defined, per channel:
  - A hold position hp and timer are kept.
  - At each window close, if count >= hp: hp <= count and the timer is loaded with HOLD_PERIODS.
  - Else the timer decrements; once it is 0, hp decrements by 1 per window.
  - The bar ORs in bit hp-1 when hp > 0.
- LEVEL_METER_PEAK_HOLD_EN not defined: no hold registers, and the bar is exactly the count thermometer plus the clip LED.

## Structure
- Package level_meter_pkg:
  - count width constant $clog2(LEDS);
  - function mag-to-count (threshold/MSB search);
  - function count-to-thermometer.
- Sub-module level_meter_channel, instantiated twice (left, right): magnitude, window peak, ballistics, clip timer, optional hold. Outputs a LEDS-bit bar.
- Top level holds the shared sample counter, window-close strobe, pending register and output handshake.

## Test plan
Unless stated otherwise, UPDATE_SAMPLES=4 and CLIP_HOLD=2.
- Reset, then left=16384 and right=1 for 4 samples with o_ready=1 -> o_valid at edge N+2 with o_data={16'h7FFF... no: 16'h7FFF, 16'h0001}. That is, left LEDs 0-14 lit and right LED 0 lit.
- Left=-32768 for one window, then 0 -> left bar 0xFFFF in window 1. In following windows the clip LED is lit for 2 more frames and the count falls 15->14->13…
- o_ready=0 across 3 window closes, then 1 -> first frame held stable; after the handshake the third (latest) frame is presented and the second is never emitted.
- Sample on the window-close cycle with mag 255 after a window with peak 4095 -> the next window's count is derived from a peak of at least 255, not reset to 0.
- Reset asserted mid-window and while o_valid=1 -> o_valid and o_data are 0 immediately, and the next frame appears only after 4 new samples.
- LEVEL_METER_PEAK_HOLD_EN with HOLD_PERIODS=2: one window at 16384, then silence -> a dot at bit 14 is held 2 windows, then steps down one LED per window while the bar falls independently.
